// File: rtl/lsu_handshake_unit.sv
// Load/store unit: takes one memory instruction per valid/ready handshake, runs it over a
// req/gnt/rvalid data port, and holds the aligned/extended result until writeback accepts it.
module lsu_handshake_unit #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [2:0]        op_i,
    input  logic [XLEN-1:0]   base_i,
    input  logic [XLEN-1:0]   offset_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   out_data_o,
    output logic              out_is_load_o,
    output logic              out_misaligned_o,
    output logic              out_timeout_o
);
    localparam int NB    = XLEN / 8;
    localparam int AW    = (NB > 1) ? $clog2(NB) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, RESP} state_e;

    // Access size code: 0 byte, 1 half, 2 word
    function automatic logic [1:0] size_of(input logic [2:0] op);
        case (op)
            3'd0, 3'd1, 3'd7: size_of = 2'd0;
            3'd2, 3'd3, 3'd6: size_of = 2'd1;
            default:          size_of = 2'd2;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'd0:    size_mask = XLEN'(8'hFF);
            2'd1:    size_mask = XLEN'(16'hFFFF);
            default: size_mask = XLEN'(32'hFFFF_FFFF);
        endcase
    endfunction

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [AW-1:0]     off_q, off_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [NB-1:0]     be_q, be_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   odata_q, odata_d;
    logic              oload_q, oload_d;
    logic              omis_q, omis_d;
    logic              oto_q, oto_d;

    logic [XLEN-1:0]   sum;
    logic [ADDR_W-1:0] eff_addr;
    logic [AW-1:0]     in_a;
    logic [1:0]        in_size;
    logic              in_is_load;
    logic              in_misaligned;
    logic [NB-1:0]     in_be;
    logic [XLEN-1:0]   in_wdata;

    assign sum = base_i + offset_i;

    generate
        if (ADDR_W <= XLEN) begin : g_addr_trunc
            assign eff_addr = sum[ADDR_W-1:0];
        end else begin : g_addr_ext
            assign eff_addr = {{(ADDR_W - XLEN){1'b0}}, sum};
        end
    endgenerate

    assign in_a       = sum[AW-1:0];
    assign in_size    = size_of(op_i);
    assign in_is_load = (op_i <= 3'd4);
    assign in_wdata   = (wdata_i & size_mask(in_size)) << {in_a, 3'b000};

    always_comb begin
        in_be         = '0;
        in_misaligned = 1'b0;
        case (in_size)
            2'd0: in_be = NB'(1) << in_a;
            2'd1: begin
                in_be         = NB'(2'b11) << in_a;
                in_misaligned = in_a[0];
            end
            default: begin
                in_be         = NB'(4'hF) << in_a;
                in_misaligned = ((in_a & AW'(3)) != '0);
            end
        endcase
    end

    // Load path: shift the addressed lane down, then sign- or zero-fill above the access size
    logic [XLEN-1:0] rsh;
    logic [XLEN-1:0] lmask;
    logic            lsign;
    logic [XLEN-1:0] load_ext;

    assign rsh   = mem_rdata_i >> {off_q, 3'b000};
    assign lmask = size_mask(size_of(op_q));

    always_comb begin
        case (size_of(op_q))
            2'd0:    lsign = rsh[7];
            2'd1:    lsign = rsh[15];
            default: lsign = rsh[31];
        endcase
        if (op_q != 3'd0 && op_q != 3'd2 && op_q != 3'd4) begin
            lsign = 1'b0;
        end
    end

    assign load_ext = (rsh & lmask) | (lsign ? ~lmask : '0);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        off_d   = off_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        cnt_d   = cnt_q;
        odata_d = odata_q;
        oload_d = oload_q;
        omis_d  = omis_q;
        oto_d   = oto_q;
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    op_d    = op_i;
                    off_d   = in_a;
                    addr_d  = eff_addr & ~ADDR_W'(NB - 1);
                    be_d    = in_be;
                    wdata_d = in_wdata;
                    we_d    = ~in_is_load;
                    cnt_d   = '0;
                    odata_d = '0;
                    oload_d = in_is_load;
                    omis_d  = in_misaligned;
                    oto_d   = 1'b0;
                    state_d = in_misaligned ? RESP : REQ;
                end
            end
            REQ: begin
                if (mem_gnt_i) begin
                    state_d = we_q ? RESP : WAIT_RSP;
                    cnt_d   = '0;
                end
            end
            WAIT_RSP: begin
                if (mem_rvalid_i) begin
                    odata_d = load_ext;
                    state_d = RESP;
                end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
                    oto_d   = 1'b1;
                    odata_d = '0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            op_q    <= '0;
            off_q   <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            cnt_q   <= '0;
            odata_q <= '0;
            oload_q <= 1'b0;
            omis_q  <= 1'b0;
            oto_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            off_q   <= off_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
            odata_q <= odata_d;
            oload_q <= oload_d;
            omis_q  <= omis_d;
            oto_q   <= oto_d;
        end
    end

    assign in_ready_o       = (state_q == IDLE);
    assign mem_req_o        = (state_q == REQ);
    assign out_valid_o      = (state_q == RESP);
    assign mem_we_o         = we_q;
    assign mem_addr_o       = addr_q;
    assign mem_be_o         = be_q;
    assign mem_wdata_o      = wdata_q;
    assign out_data_o       = odata_q;
    assign out_is_load_o    = oload_q;
    assign out_misaligned_o = omis_q;
    assign out_timeout_o    = oto_q;

endmodule
